// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store initiator: funct3 codes,
// FSM state encoding, and the size/legality decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Access size in bytes; only funct3[1:0] carries the size.
  function automatic logic [2:0] nbytes_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic load_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the assembled little-endian load bytes to 32 bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] asm_data,
  output logic [31:0] ext_data
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ext_data = '0;
    case (funct3)
      F3_B:    ext_data = {{24{asm_data[7]}}, asm_data[7:0]};
      F3_H:    ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
      F3_W:    ext_data = asm_data;
      F3_BU:   ext_data = {24'd0, asm_data[7:0]};
      F3_HU:   ext_data = {16'd0, asm_data[15:0]};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_initiator.sv
// Splits core load/store requests into sequential little-endian byte
// transactions on a byte-wide memory port and returns one response per request.
module lsu_byte_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [1:0]        last_idx;
  logic              req_legal;
  logic [31:0]       ext_data;

  lsu_load_ext u_load_ext (
    .funct3   (funct3_q),
    .asm_data (asm_q),
    .ext_data (ext_data)
  );

  assign last_idx = 2'(nbytes_of(funct3_q) - 3'd1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    req_legal  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        req_legal = req_we ? store_legal(req_funct3) : load_legal(req_funct3);
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          byte_cnt_d = '0;
          asm_d      = '0;
          err_d      = !req_legal;
          state_d    = req_legal ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        // Everything presented here comes from registered state, so it is
        // inherently stable across mem_ready stalls.
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_W'(byte_cnt_q);
        mem_wdata = wdata_q[{byte_cnt_q, 3'b000} +: 8];
        if (mem_ready) begin
          if (!we_q) asm_d[{byte_cnt_q, 3'b000} +: 8] = mem_rdata;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == last_idx) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : ext_data;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; all next-state
  // math lives in the always_comb above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_initiator.sv
// Directed bench for lsu_byte_initiator against a 64-byte memory model with
// programmable wait states.
module tb_lsu_byte_initiator;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  int tests = 0;
  int fails = 0;

  // Memory model: preset contents from the stimulus, written bytes from stores.
  logic [7:0] rom   [64];
  logic [7:0] wmem  [64];
  logic       wvalid[64];
  int         stall = 0;
  int         wait_cnt = 0;
  int         wr_n = 0;
  int         rd_n = 0;
  int         resp_cnt = 0;
  logic [ADDR_W-1:0] wr_a [64];
  logic [7:0]        wr_d [64];
  logic [ADDR_W-1:0] rd_a [64];

  always #5 clk = ~clk;

  lsu_byte_initiator #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_ready = (wait_cnt >= stall);
  assign mem_rdata = wvalid[mem_addr] ? wmem[mem_addr] : rom[mem_addr];

  initial for (int i = 0; i < 64; i++) wvalid[i] = 1'b0;

  always @(posedge clk) begin
    if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
    if (mem_valid && mem_ready) begin
      if (mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
        wr_a[wr_n[5:0]]  <= mem_addr;
        wr_d[wr_n[5:0]]  <= mem_wdata;
        wr_n             <= wr_n + 1;
      end else begin
        rd_a[rd_n[5:0]] <= mem_addr;
        rd_n            <= rd_n + 1;
      end
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request for a cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_resp(input int bound, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One complete load against preset memory: response value and cycle count.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] exp_data, input int exp_cyc);
    int cyc;
    issue(1'b0, f3, addr, 32'h0);
    wait_resp(20, cyc);
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_rdata"}, resp_rdata, exp_data);
    check({tag, "_err"}, resp_err, 0);
    check({tag, "_cycles"}, cyc, exp_cyc);
    @(negedge clk);
    check({tag, "_idle_again"}, {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int cyc;
    int base;
    int rbase;
    int rcnt;
    logic [31:0] sw_data;

    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[8]  = 8'h80;
    rom[10] = 8'h34;
    rom[11] = 8'h92;
    rom[62] = 8'h11;
    rom[63] = 8'h22;
    rom[0]  = 8'h33;
    rom[1]  = 8'h44;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);

    check("rst_req_ready",  req_ready,  1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err",   resp_err,   0);
    check("rst_mem_valid",  mem_valid,  0);
    check("rst_mem_we",     mem_we,     0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);
    rst_n = 1'b1;

    // SW 0xDEADBEEF at 4: one byte per cycle, lowest address first.
    sw_data = 32'hDEADBEEF;
    base = wr_n;
    issue(1'b1, 3'b010, 6'd4, sw_data);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_valid_%0d", k), {mem_valid, mem_we, req_ready}, 3'b110);
      check($sformatf("sw_addr_%0d", k),  mem_addr,  4 + k);
      check($sformatf("sw_wdata_%0d", k), mem_wdata, sw_data[8*k +: 8]);
      @(negedge clk);
    end
    check("sw_resp", {resp_valid, resp_err, mem_valid}, 3'b100);
    check("sw_rdata", resp_rdata, 0);
    check("sw_nwrites", wr_n - base, 4);
    check("sw_wr_order", {wr_a[base[5:0]], wr_a[base[5:0]+6'd3]}, {6'd4, 6'd7});
    @(negedge clk);
    check("sw_idle_again", {resp_valid, req_ready}, 2'b01);

    do_load("lb",  3'b000, 6'd8,  32'hFFFFFF80, 1);
    do_load("lbu", 3'b100, 6'd8,  32'h00000080, 1);
    do_load("lh",  3'b001, 6'd10, 32'hFFFF9234, 2);
    do_load("lhu", 3'b101, 6'd10, 32'h00009234, 2);

    // LW wrapping past the top of the address space.
    rbase = rd_n;
    do_load("lw_wrap", 3'b010, 6'd62, 32'h44332211, 4);
    check("lw_nreads", rd_n - rbase, 4);
    check("lw_addrs", {rd_a[rbase[5:0]], rd_a[rbase[5:0]+6'd1], rd_a[rbase[5:0]+6'd2],
                       rd_a[rbase[5:0]+6'd3]}, {6'd62, 6'd63, 6'd0, 6'd1});

    // SH with three wait states per byte; outputs must hold through the stall.
    stall = 3;
    base = wr_n;
    issue(1'b1, 3'b001, 6'd20, 32'h1234A55A);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sh_hold_%0d", i), {mem_valid, mem_we, req_ready}, 3'b110);
      check($sformatf("sh_addr_%0d", i), mem_addr, 20 + i / 4);
      check($sformatf("sh_wdata_%0d", i), mem_wdata, (i < 4) ? 8'h5A : 8'hA5);
      @(negedge clk);
    end
    check("sh_resp", {resp_valid, resp_err, mem_valid}, 3'b100);
    check("sh_nwrites", wr_n - base, 2);
    check("sh_bytes", {wmem[21], wmem[20]}, 16'hA55A);
    @(negedge clk);
    stall = 0;

    // Illegal funct3 for each direction: no memory access, error response.
    base = wr_n;
    rbase = rd_n;
    issue(1'b0, 3'b011, 6'd8, 32'h0);
    check("ill_ld_resp", {mem_valid, resp_valid, resp_err}, 3'b011);
    check("ill_ld_rdata", resp_rdata, 0);
    @(negedge clk);
    check("ill_ld_idle", {resp_valid, req_ready}, 2'b01);
    issue(1'b1, 3'b100, 6'd40, 32'hFFFFFFFF);
    check("ill_st_resp", {mem_valid, resp_valid, resp_err}, 3'b011);
    check("ill_st_rdata", resp_rdata, 0);
    @(negedge clk);
    check("ill_no_mem", (wr_n - base) + (rd_n - rbase), 0);

    // Reset while the second byte of a store is on the bus.
    base = wr_n;
    rcnt = resp_cnt;
    issue(1'b1, 3'b010, 6'd30, 32'h87654321);
    check("rst_mid_byte0", mem_addr, 30);
    @(negedge clk);
    check("rst_mid_byte1", mem_addr, 31);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_drop", {mem_valid, resp_valid, req_ready}, 3'b001);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_resp", resp_cnt - rcnt, 0);
    check("rst_mid_nwrites", wr_n - base, 2);
    check("rst_mid_byte2_untouched", wvalid[32], 0);
    do_load("post_rst_lbu", 3'b100, 6'd31, 32'h00000043, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
